uart_cmd_bridge: RTL and testbench
==================================

// Module: uart_cmd_bridge
// PURPOSE
//  Host-facing command responder at the far end of the UART byte interface.
//  Parses byte packets from the UART receiver and executes register-bus reads/writes.
//  Replies through the UART transmitter: 'K' for a write, the data byte for a read, '?' for an unknown command.
//  Sits between uart (rx_byte/received, tx_byte/transmit) and the on-chip 8-bit register bus.
// PARAMETERS
//  TIMEOUT_CYCLES  100000  max clk cycles between bytes of one packet before the partial packet is dropped
//  TO_W            17      width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk              in   1  clock
//  rst              in   1  reset, synchronous, active-high
//  rx_byte          in   8  byte from UART receiver
//  received         in   1  one-cycle strobe: rx_byte valid
//  recv_error       in   1  one-cycle strobe: UART framing error
//  is_transmitting  in   1  UART transmitter busy
//  tx_byte          out  8  reply byte to UART transmitter
//  transmit         out  1  one-cycle strobe: start sending tx_byte
//  bus_req          out  1  bus request, held until bus_ready
//  bus_we           out  1  1 = write, 0 = read; valid while bus_req
//  bus_addr         out  8  bus address; valid while bus_req
//  bus_wdata        out  8  write data; valid while bus_req && bus_we
//  bus_rdata        in   8  read data; sampled when bus_ready && !bus_we
//  bus_ready        in   1  bus completion; ends the request in the same cycle
//  cmd_error        out  1  one-cycle strobe: packet aborted (timeout, recv_error, checksum)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timeout counter cleared. Applies mid-packet and mid-bus-request:
//   bus_req drops on the next edge and no reply is sent.
//  Packets: write = 0x57 'W', addr, data. Read = 0x52 'R', addr. Any other first byte -> reply 0x3F '?'.
//  States:
//   IDLE -> GET_ADDR on received with 'W'/'R'; latch cmd. Other byte -> REPLY_WAIT with tx_byte = 0x3F.
//   GET_ADDR -> GET_DATA ('W') or BUS ('R') on received; latch bus_addr.
//   GET_DATA -> BUS on received; latch bus_wdata.
//   BUS: bus_req = 1 until bus_ready (1 cycle minimum). On bus_ready go to REPLY_WAIT with
//    tx_byte = 0x4B 'K' (write) or bus_rdata (read).
//   REPLY_WAIT: wait for is_transmitting == 0, then go to REPLY_PULSE.
//   REPLY_PULSE: transmit = 1 for exactly one cycle -> REPLY_ACK.
//   REPLY_ACK: wait for is_transmitting == 1 (UART accepted the byte) -> IDLE.
//  Timeout counter: cleared on every received and in IDLE; increments in GET_ADDR/GET_DATA.
//   Reaching TIMEOUT_CYCLES -> cmd_error pulse, go to IDLE, no reply.
//  recv_error in GET_ADDR/GET_DATA -> cmd_error pulse, go to IDLE, no reply. recv_error in IDLE is ignored.
//  Bytes received in BUS/REPLY_* states are discarded; no queueing.
//  received and recv_error in the same cycle: recv_error wins.
//  Bus latency unbounded; no bus timeout.
//  tx_byte holds its value from entry to REPLY_WAIT until the next reply.
//  Minimum latency, last rx byte to transmit: 3 cycles (write, bus_ready immediate, UART idle).
// CONFIGURATION
//  UART_CMD_CHECKSUM_EN defined:
//   - Every packet carries a trailing checksum byte = XOR of all preceding packet bytes.
//   - Extra state GET_SUM precedes BUS.
//   - Mismatch -> cmd_error pulse, no bus access, reply 0x21 '!'.
//   - Unknown command still gets '?' immediately; no checksum byte expected.
//   - Timeout also applies in GET_SUM.
//  Undefined: no checksum byte; GET_SUM absent; 0x21 never sent.
// TESTING
//  1. 'W',0x10,0xA5; bus_ready after 2 cycles -> one write: addr 0x10, wdata 0xA5; then one transmit with tx_byte 0x4B.
//  2. 'R',0x22; bus_rdata 0x3C with bus_ready -> bus_we 0; one transmit with tx_byte 0x3C.
//  3. Byte 0x00 -> no bus_req; transmit with 0x3F. is_transmitting held 1 for 50 cycles -> transmit waits until it falls.
//  4. 'W',0x10 then silence > TIMEOUT_CYCLES (set 100) -> cmd_error pulse, no bus_req, no transmit;
//     a following 'R',0x01 is serviced normally.
//  5. recv_error after 'R' -> cmd_error, IDLE. rst asserted during BUS -> bus_req 0 next cycle, no transmit.
//  6. UART_CMD_CHECKSUM_EN: 'W',0x10,0xA5,0xE2 -> write + 'K'.
//     'W',0x10,0xA5,0x00 -> cmd_error, no write, reply 0x21.

Source files
------------

// File: rtl/uart_cmd_bridge_if.sv
// rtl/uart_cmd_bridge_if.sv - 8-bit register-bus handshake between uart_cmd_bridge and the bus target
interface uart_cmd_bridge_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;

  modport master (output req, output we, output addr, output wdata, input rdata, input ready);
  modport slave  (input req, input we, input addr, input wdata, output rdata, output ready);
endinterface

// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART byte-packet command responder executing register-bus reads/writes
// Optional trailing XOR checksum byte: define UART_CMD_CHECKSUM_EN.
module uart_cmd_bridge #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     received,
  input  logic                     recv_error,
  input  logic                     is_transmitting,
  output logic [7:0]               tx_byte,
  output logic                     transmit,
  output logic                     cmd_error,
  uart_cmd_bridge_if.master        bus
);
  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_UNK = 8'h3F;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_CHECKSUM_EN
  localparam logic [7:0] RSP_BAD = 8'h21;
  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS, REPLY_WAIT, REPLY_PULSE, REPLY_ACK, GET_SUM
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS, REPLY_WAIT, REPLY_PULSE, REPLY_ACK
  } state_t;
`endif

  state_t          state;
  logic            is_wr;
  logic [TO_W-1:0] to_cnt;
  logic            collecting;
  logic            timed_out;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      sum;
  assign collecting = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_SUM);
`else
  assign collecting = (state == GET_ADDR) || (state == GET_DATA);
`endif

  // A byte arriving on the last allowed cycle still counts as in time.
  assign timed_out = !received && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      is_wr     <= 1'b0;
      to_cnt    <= '0;
      tx_byte   <= 8'h00;
      transmit  <= 1'b0;
      cmd_error <= 1'b0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= 8'h00;
      bus.wdata <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
      sum       <= 8'h00;
`endif
    end else begin
      transmit  <= 1'b0;
      cmd_error <= 1'b0;
      if (collecting && (recv_error || timed_out)) begin
        cmd_error <= 1'b1;
        to_cnt    <= '0;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            to_cnt <= '0;
            if (received && !recv_error) begin
              if (rx_byte == CMD_W || rx_byte == CMD_R) begin
                is_wr <= (rx_byte == CMD_W);
                state <= GET_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                sum   <= rx_byte;
`endif
              end else begin
                tx_byte <= RSP_UNK;
                state   <= REPLY_WAIT;
              end
            end
          end
          GET_ADDR: begin
            if (received) begin
              to_cnt   <= '0;
              bus.addr <= rx_byte;
`ifdef UART_CMD_CHECKSUM_EN
              sum      <= sum ^ rx_byte;
              state    <= is_wr ? GET_DATA : GET_SUM;
`else
              if (is_wr) begin
                state <= GET_DATA;
              end else begin
                bus.req <= 1'b1;
                bus.we  <= 1'b0;
                state   <= BUS;
              end
`endif
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
          GET_DATA: begin
            if (received) begin
              to_cnt    <= '0;
              bus.wdata <= rx_byte;
`ifdef UART_CMD_CHECKSUM_EN
              sum       <= sum ^ rx_byte;
              state     <= GET_SUM;
`else
              bus.req   <= 1'b1;
              bus.we    <= 1'b1;
              state     <= BUS;
`endif
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
`ifdef UART_CMD_CHECKSUM_EN
          GET_SUM: begin
            if (received) begin
              to_cnt <= '0;
              if (rx_byte == sum) begin
                bus.req <= 1'b1;
                bus.we  <= is_wr;
                state   <= BUS;
              end else begin
                cmd_error <= 1'b1;
                tx_byte   <= RSP_BAD;
                state     <= REPLY_WAIT;
              end
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
`endif
          BUS: begin
            if (bus.ready) begin
              bus.req <= 1'b0;
              tx_byte <= is_wr ? RSP_OK : bus.rdata;
              state   <= REPLY_WAIT;
            end
          end
          REPLY_WAIT: begin
            if (!is_transmitting) begin
              transmit <= 1'b1;
              state    <= REPLY_PULSE;
            end
          end
          REPLY_PULSE: state <= REPLY_ACK;
          // Hold off new packets until the UART has visibly taken the byte.
          REPLY_ACK: begin
            if (is_transmitting) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - randomized self-checking bench for uart_cmd_bridge
// Honours UART_CMD_CHECKSUM_EN when the design is built with it.
module tb_uart_cmd_bridge;
  localparam int TO = 100;
  localparam logic [7:0] W = 8'h57;
  localparam logic [7:0] R = 8'h52;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       received = 1'b0;
  logic       recv_error = 1'b0;
  logic       is_transmitting = 1'b0;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       cmd_error;

  uart_cmd_bridge_if bif ();

  uart_cmd_bridge #(.TIMEOUT_CYCLES(TO), .TO_W(17)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received), .recv_error(recv_error),
    .is_transmitting(is_transmitting), .tx_byte(tx_byte), .transmit(transmit),
    .cmd_error(cmd_error), .bus(bif.master)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed activity
  int          cyc = 0;
  int          tx_cnt = 0;
  int          err_cnt = 0;
  int          tx_cyc = 0;
  int          rx_cyc = 0;
  logic [7:0]  tx_q[$];
  logic [16:0] op_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bif.req && bif.ready) op_q.push_back({bif.we, bif.addr, (bif.we ? bif.wdata : 8'h00)});
    if (transmit) begin
      tx_q.push_back(tx_byte);
      tx_cnt++;
      tx_cyc = cyc;
    end
    if (cmd_error) err_cnt++;
    if (received) rx_cyc = cyc;
  end

  // Reference model: expected replies, bus operations, abort count, register contents
  logic [7:0]  ref_mem[256];
  logic [7:0]  exp_tx_q[$];
  logic [16:0] exp_op_q[$];
  int          exp_tx_n = 0;
  int          exp_err_n = 0;

  // Bus target with programmable or random latency
  logic [7:0] slv_mem[256];
  int         slv_lat = -1;

  initial begin : bus_slave
    int wait_n;
    int lat;
    wait_n = 0;
    lat = 0;
    bif.ready = 1'b0;
    bif.rdata = 8'h00;
    for (int i = 0; i < 256; i++) slv_mem[i] = 8'(i * 7 + 3);
    forever begin
      @(posedge clk);
      #1;
      if (bif.ready) begin
        bif.ready = 1'b0;
        bif.rdata = 8'($urandom);
        wait_n = 0;
      end else if (bif.req) begin
        if (wait_n >= lat) begin
          bif.ready = 1'b1;
          bif.rdata = slv_mem[bif.addr];
          if (bif.we) slv_mem[bif.addr] = bif.wdata;
        end else begin
          wait_n++;
        end
      end else begin
        wait_n = 0;
        lat = (slv_lat < 0) ? int'($urandom_range(0, 3)) : slv_lat;
        bif.rdata = 8'($urandom);
      end
    end
  end

  // UART transmitter: busy for a few cycles after each transmit strobe
  logic hold_busy = 1'b0;
  initial begin : uart_model
    int busy_n;
    busy_n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (transmit) busy_n = int'($urandom_range(2, 6));
      else if (busy_n > 0) busy_n--;
      is_transmitting = hold_busy || (busy_n > 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    received = 1'b1;
    tick(1);
    received = 1'b0;
  endtask

  // Sends the first nsend bytes of a well-formed packet (all of it when nsend < 0).
  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] d,
                          input int nsend, input int max_gap);
    logic [7:0] q[$];
    int n;
    q.push_back(cmd);
    q.push_back(a);
    if (cmd == W) q.push_back(d);
`ifdef UART_CMD_CHECKSUM_EN
    q.push_back(cmd ^ a ^ ((cmd == W) ? d : 8'h00));
`endif
    n = (nsend < 0 || nsend > q.size()) ? q.size() : nsend;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick(int'($urandom_range(0, max_gap)));
      send_byte(q[i]);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int max_gap);
    send_pkt(W, a, d, -1, max_gap);
    exp_op_q.push_back({1'b1, a, d});
    ref_mem[a] = d;
    exp_tx_q.push_back(8'h4B);
    exp_tx_n++;
  endtask

  task automatic do_read(input logic [7:0] a, input int max_gap);
    send_pkt(R, a, 8'h00, -1, max_gap);
    exp_op_q.push_back({1'b0, a, 8'h00});
    exp_tx_q.push_back(ref_mem[a]);
    exp_tx_n++;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((tx_cnt != exp_tx_n || err_cnt != exp_err_n || is_transmitting) && n < 400) begin
      tick(1);
      n++;
    end
    tick(3);
    check("tx_count", tx_cnt, exp_tx_n);
    check("err_count", err_cnt, exp_err_n);
    check("op_count", op_q.size(), exp_op_q.size());
    while (tx_q.size() > 0 && exp_tx_q.size() > 0) check("reply_byte", tx_q.pop_front(), exp_tx_q.pop_front());
    while (op_q.size() > 0 && exp_op_q.size() > 0) check("bus_op", op_q.pop_front(), exp_op_q.pop_front());
    tx_q.delete();
    op_q.delete();
    exp_tx_q.delete();
    exp_op_q.delete();
    tx_cnt = exp_tx_n;
    err_cnt = exp_err_n;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int n;
    int kind;
    int len;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] b;
    logic [7:0] c;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

    tick(3);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_transmit", transmit, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_bus_req", bif.req, 0);
    check("rst_bus_we", bif.we, 0);
    check("rst_bus_addr", bif.addr, 0);
    check("rst_bus_wdata", bif.wdata, 0);
    rst = 1'b0;
    tick(2);

    slv_lat = 2;
    do_write(8'h10, 8'hA5, 4);
    settle();

    slv_mem[8'h22] = 8'h3C;
    ref_mem[8'h22] = 8'h3C;
    slv_lat = -1;
    do_read(8'h22, 4);
    settle();

    hold_busy = 1'b1;
    tick(1);
    t0 = tx_cnt;
    send_byte(8'h00);
    exp_tx_q.push_back(8'h3F);
    exp_tx_n++;
    tick(50);
    check("busy_no_tx", tx_cnt, t0);
    hold_busy = 1'b0;
    settle();

    slv_lat = 0;
    do_write(8'h33, 8'h5A, 0);
    settle();
    check("latency", tx_cyc - rx_cyc, 3);
    slv_lat = -1;

    send_pkt(W, 8'h10, 8'h00, 2, 0);
    exp_err_n++;
    settle();
    do_read(8'h01, 5);
    settle();

    send_pkt(R, 8'h00, 8'h00, 1, 0);
    tick(3);
    recv_error = 1'b1;
    tick(1);
    recv_error = 1'b0;
    exp_err_n++;
    settle();

    slv_lat = 40;
    send_pkt(R, 8'h05, 8'h00, -1, 3);
    n = 0;
    while (!bif.req && n < 20) begin
      tick(1);
      n++;
    end
    check("bus_req_seen", bif.req, 1);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_bus_req", bif.req, 0);
    rst = 1'b0;
    tick(60);
    slv_lat = -1;
    settle();

`ifdef UART_CMD_CHECKSUM_EN
    send_byte(W); send_byte(8'h10); send_byte(8'hA5); send_byte(8'h00);
    exp_err_n++;
    exp_tx_q.push_back(8'h21);
    exp_tx_n++;
    settle();
`endif

    for (int p = 0; p < 50; p++) begin
`ifdef UART_CMD_CHECKSUM_EN
      kind = int'($urandom_range(0, 10));
`else
      kind = int'($urandom_range(0, 9));
`endif
      a = 8'($urandom);
      d = 8'($urandom);
      c = $urandom_range(0, 1) ? W : R;
      len = ((c == W) ? 3 : 2);
`ifdef UART_CMD_CHECKSUM_EN
      len++;
`endif
      case (kind)
        0, 1, 2: do_write(a, d, 20);
        3, 4, 5: do_read(a, 20);
        6: begin
          do b = 8'($urandom); while (b == W || b == R);
          send_byte(b);
          exp_tx_q.push_back(8'h3F);
          exp_tx_n++;
        end
        7: begin
          send_pkt(c, a, d, int'($urandom_range(1, len - 1)), 20);
          exp_err_n++;
        end
        8: begin
          send_pkt(c, a, d, int'($urandom_range(1, len - 1)), 20);
          tick(int'($urandom_range(0, 20)));
          recv_error = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            received = 1'b1;
            rx_byte  = 8'($urandom);
          end
          tick(1);
          recv_error = 1'b0;
          received   = 1'b0;
          exp_err_n++;
        end
        9: begin
          recv_error = 1'b1;
          tick(1);
          recv_error = 1'b0;
          tick(2);
          do_write(a, d, 5);
        end
        default: begin
          b = W ^ a ^ d ^ 8'($urandom_range(1, 255));
          send_byte(W); send_byte(a); send_byte(d); send_byte(b);
          exp_err_n++;
          exp_tx_q.push_back(8'h21);
          exp_tx_n++;
        end
      endcase
      settle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
